// File: rtl/mode_fifo_reader.sv
// Consumer-side controller for the AES mode FIFO: mirrors occupancy from the write strobe,
// issues pops, captures the popped mode code and presents it over a valid/ready handshake.
module mode_fifo_reader #(
  parameter int unsigned FIFO_SZ = 5,
  parameter int unsigned MODE_W  = 2,
  parameter int unsigned OCC_W   = $clog2(FIFO_SZ + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_in,
  input  logic              fifo_full,
  input  logic [MODE_W-1:0] fifo_outp,
  output logic              fifo_pop,
  output logic [MODE_W-1:0] mode_out,
  output logic              mode_valid,
  input  logic              mode_ready,
  output logic [OCC_W-1:0]  occupancy,
  output logic              empty,
  output logic              overflow
);

  localparam logic [OCC_W-1:0] FullCnt = OCC_W'(FIFO_SZ);
  localparam logic [OCC_W-1:0] OneCnt  = OCC_W'(1);

  typedef enum logic [1:0] {StIdle, StCapt, StPresent} state_e;

  state_e              state_q, state_d;
  logic [OCC_W-1:0]    occ_q, occ_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic                overflow_q, overflow_d;
  logic                occ_nonzero;
  logic                occ_full;
  logic                full_push;

  assign occ_nonzero = (occ_q != '0);
  assign occ_full    = (occ_q == FullCnt);
  assign full_push   = push_in && occ_full;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        // A pop is deferred in any push cycle; the FIFO cannot count a simultaneous push and pop.
        if (occ_nonzero && !push_in) begin
          state_d = StCapt;
        end
      end
      StCapt: begin
        state_d = StPresent;
      end
      StPresent: begin
        if (mode_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output logic.
  always_comb begin
    fifo_pop   = 1'b0;
    mode_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        fifo_pop = occ_nonzero && !push_in;
      end
      StCapt: begin
        fifo_pop = 1'b0;
      end
      StPresent: begin
        mode_valid = 1'b1;
      end
      default: begin
        fifo_pop   = 1'b0;
        mode_valid = 1'b0;
      end
    endcase
  end

  // Occupancy mirror; a push at full overwrites the oldest entry so the count saturates.
  always_comb begin
    occ_d = occ_q;
    if (push_in && !occ_full) begin
      occ_d = occ_q + OneCnt;
    end else if (fifo_pop) begin
      occ_d = occ_q - OneCnt;
    end
  end

  assign overflow_d = overflow_q || full_push;

  // The FIFO output register is valid the cycle after the pop, which is exactly StCapt.
  always_comb begin
    mode_d = mode_q;
    if (state_q == StCapt) begin
      mode_d = fifo_outp;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q      <= '0;
      mode_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      mode_q     <= mode_d;
      overflow_q <= overflow_d;
    end
  end

  assign mode_out  = mode_q;
  assign occupancy = occ_q;
  assign empty     = !occ_nonzero;
  assign overflow  = overflow_q;

`ifndef SYNTHESIS
  logic full_push_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      full_push_q <= 1'b0;
    end else begin
      full_push_q <= full_push;
    end
  end

  a_no_pop_on_push: assert property (@(posedge clk) disable iff (reset) !(fifo_pop && push_in));
  a_no_pop_empty:   assert property (@(posedge clk) disable iff (reset) fifo_pop |-> occ_nonzero);
  a_occ_bound:      assert property (@(posedge clk) disable iff (reset) occ_q <= FullCnt);
  a_full_xcheck:    assert property (@(posedge clk) disable iff (reset)
                                     fifo_full |-> (occ_full || full_push_q));
  a_mode_stable:    assert property (@(posedge clk) disable iff (reset)
                                     (mode_valid && !mode_ready) |=> $stable(mode_out));
`endif

endmodule

// File: tb/tb_mode_fifo_reader.sv
// Bench for mode_fifo_reader: behavioural mode FIFO, directed stimulus, and a scoreboard
// monitor that checks every accepted mode code in order.
module tb_mode_fifo_reader;

  localparam int FIFO_SZ = 5;
  localparam int MODE_W  = 2;
  localparam int OCC_W   = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              push_in;
  logic [MODE_W-1:0] push_data;
  logic              fifo_full;
  logic [MODE_W-1:0] fifo_outp;
  logic              fifo_pop;
  logic [MODE_W-1:0] mode_out;
  logic              mode_valid;
  logic              mode_ready;
  logic [OCC_W-1:0]  occupancy;
  logic              empty;
  logic              overflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [MODE_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  mode_fifo_reader #(
    .FIFO_SZ (FIFO_SZ),
    .MODE_W  (MODE_W),
    .OCC_W   (OCC_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .push_in    (push_in),
    .fifo_full  (fifo_full),
    .fifo_outp  (fifo_outp),
    .fifo_pop   (fifo_pop),
    .mode_out   (mode_out),
    .mode_valid (mode_valid),
    .mode_ready (mode_ready),
    .occupancy  (occupancy),
    .empty      (empty),
    .overflow   (overflow)
  );

  // Mode FIFO: registered output, a push at full overwrites the oldest entry.
  logic [MODE_W-1:0] mem [FIFO_SZ];
  int wp, rp, cnt;

  always @(posedge clk) begin
    if (reset) begin
      wp        <= 0;
      rp        <= 0;
      cnt       <= 0;
      fifo_full <= 1'b0;
      fifo_outp <= '0;
    end else if (fifo_pop) begin
      fifo_outp <= mem[rp];
      rp        <= (rp + 1) % FIFO_SZ;
      cnt       <= cnt - 1;
      fifo_full <= 1'b0;
    end else if (push_in) begin
      mem[wp] <= push_data;
      wp      <= (wp + 1) % FIFO_SZ;
      if (cnt == FIFO_SZ) begin
        rp        <= (rp + 1) % FIFO_SZ;
        fifo_full <= 1'b1;
      end else begin
        cnt <= cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled at the falling edge.
  task automatic step(input logic rst, input logic p, input logic [MODE_W-1:0] d,
                      input logic r);
    @(posedge clk);
    #2;
    reset      = rst;
    push_in    = p;
    push_data  = d;
    mode_ready = r;
    @(negedge clk);
  endtask

  // Scoreboard monitor.
  initial begin
    logic              hold_prev;
    logic [MODE_W-1:0] held_mode;
    logic              full_push_prev;
    logic [MODE_W-1:0] expc;
    hold_prev      = 1'b0;
    held_mode      = '0;
    full_push_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (hold_prev) begin
        chk("hold_valid", mode_valid, 1);
        chk("hold_data", mode_out, held_mode);
      end
      if (!reset && mode_valid && mode_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_mode", 1, 0);
        end else begin
          expc = exp_q.pop_front();
          chk("mode_out", mode_out, expc);
        end
      end
      if (!reset && fifo_full && !full_push_prev) begin
        chk("full_xcheck_occ", occupancy, FIFO_SZ);
      end
      hold_prev      = !reset && mode_valid && !mode_ready;
      held_mode      = mode_out;
      full_push_prev = push_in && (cnt == FIFO_SZ);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MODE_W-1:0] ovf_codes [6];
    ovf_codes = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    reset      = 1'b1;
    push_in    = 1'b0;
    push_data  = '0;
    mode_ready = 1'b0;

    // Reset held for two cycles.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_valid", mode_valid, 0);
    chk("rst_mode", mode_out, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_empty", empty, 1);
    chk("rst_overflow", overflow, 0);
    chk("rst_pop", fifo_pop, 0);

    // Single mode with the core always ready.
    step(0, 0, 0, 1);
    step(0, 1, 2'b10, 1);
    exp_q.push_back(2'b10);
    chk("single_pop_t0", fifo_pop, 0);
    step(0, 0, 0, 1);
    chk("single_pop_t1", fifo_pop, 1);
    chk("single_occ_t1", occupancy, 1);
    step(0, 0, 0, 1);
    chk("single_empty_t2", empty, 1);
    chk("single_valid_t2", mode_valid, 0);
    step(0, 0, 0, 1);
    chk("single_valid_t3", mode_valid, 1);
    chk("single_mode_t3", mode_out, 2'b10);
    step(0, 0, 0, 1);
    chk("single_valid_t4", mode_valid, 0);

    // Ordered burst: one mode every three cycles once the pushes stop.
    for (int i = 0; i < 3; i++) begin
      step(0, 1, MODE_W'(i + 1), 1);
      exp_q.push_back(MODE_W'(i + 1));
      chk("burst_pop_in_push", fifo_pop, 0);
    end
    for (int k = 0; k < 9; k++) begin
      step(0, 0, 0, 1);
      chk("burst_pop", fifo_pop, (k % 3 == 0) ? 1 : 0);
      chk("burst_valid", mode_valid, (k % 3 == 2) ? 1 : 0);
    end
    step(0, 0, 0, 1);
    chk("burst_occ_end", occupancy, 0);

    // Overflow with the core stalled, then back-pressure in PRESENT.
    for (int i = 0; i < 6; i++) begin
      step(0, 1, ovf_codes[i], 0);
      chk("ovf_pop_in_push", fifo_pop, 0);
    end
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    step(0, 0, 0, 0);
    chk("ovf_occ_sat", occupancy, 5);
    chk("ovf_flag", overflow, 1);
    chk("ovf_pop", fifo_pop, 1);
    step(0, 0, 0, 0);
    chk("ovf_occ_capt", occupancy, 4);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0);
      chk("bp_valid", mode_valid, 1);
      chk("bp_mode", mode_out, 1);
      chk("bp_pop", fifo_pop, 0);
      chk("bp_occ", occupancy, 4);
    end
    step(0, 0, 0, 1);
    chk("bp_accept_valid", mode_valid, 1);
    step(0, 0, 0, 1);
    chk("bp_valid_drop", mode_valid, 0);
    for (int n = 0; n < 60 && exp_q.size() != 0; n++) begin
      step(0, 0, 0, 1);
    end
    chk("ovf_drain_left", exp_q.size(), 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("ovf_occ_end", occupancy, 0);
    chk("ovf_empty_end", empty, 1);
    chk("ovf_sticky", overflow, 1);

    // Reset while a code is presented and two entries remain.
    step(0, 1, 2'd3, 0);
    step(0, 1, 2'd1, 0);
    step(0, 1, 2'd2, 0);
    step(0, 0, 0, 0);
    chk("mid_pop", fifo_pop, 1);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    exp_q.delete();
    chk("mid_pre_valid", mode_valid, 1);
    chk("mid_pre_occ", occupancy, 2);
    step(0, 0, 0, 1);
    chk("mid_post_valid", mode_valid, 0);
    chk("mid_post_occ", occupancy, 0);
    chk("mid_post_pop", fifo_pop, 0);
    chk("mid_post_empty", empty, 1);
    chk("mid_post_overflow", overflow, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      chk("mid_idle_pop", fifo_pop, 0);
      chk("mid_idle_valid", mode_valid, 0);
    end

    // Normal operation resumes after reset.
    step(0, 1, 2'd3, 1);
    exp_q.push_back(2'd3);
    for (int n = 0; n < 10 && exp_q.size() != 0; n++) begin
      step(0, 0, 0, 1);
    end
    chk("post_rst_drain_left", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mode_fifo_reader.md
# mode_fifo_reader

Consumer-side controller for the AES mode FIFO. It tracks FIFO occupancy by mirroring the FIFO's write strobe, because the FIFO has no empty flag. It issues single-cycle pop strobes and captures the popped 2-bit mode code. It then presents that code to the AES round controller over a valid/ready handshake. It sits between the mode FIFO's read port and the core's per-block mode select, and also reports occupancy and overflow.

## Interface
Parameters:
- FIFO_SZ, 5, depth of the mode FIFO being read; must match the FIFO instance.
- MODE_W, 2, width of a mode code.
- OCC_W, $clog2(FIFO_SZ+1) (3 at default), width of the occupancy count.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- push_in  input  1  copy of the FIFO write strobe (ctrl_dataIn); one entry is written on each cycle it is high.
- fifo_full  input  1  FIFO full flag; informational, used only as a cross-check.
- fifo_outp  input  MODE_W  FIFO registered output; valid in the cycle after a pop.
- fifo_pop  output  1  drives FIFO ctrl_dataOut; combinational from state, occupancy and push_in.
- mode_out  output  MODE_W  registered mode code presented to the core.
- mode_valid  output  1  mode_out holds an unconsumed code.
- mode_ready  input  1  core accepts mode_out this cycle.
- occupancy  output  OCC_W  number of entries currently held in the FIFO.
- empty  output  1  occupancy == 0.
- overflow  output  1  sticky flag: a push arrived while occupancy == FIFO_SZ.

## Operation
- States: IDLE, CAPT, PRESENT.
- IDLE:
  - fifo_pop = (occupancy != 0) && !push_in.
  - If fifo_pop is high, go to CAPT; otherwise stay in IDLE.
  - Pops are never issued in a push cycle. The FIFO cannot update its count correctly on a simultaneous push and pop, so the pop is deferred.
- CAPT: mode_out <= fifo_outp; go to PRESENT. fifo_pop = 0.
- PRESENT:
  - mode_valid = 1 and mode_out is held stable.
  - On mode_valid && mode_ready, go to IDLE. Otherwise stay.
  - fifo_pop = 0.
- Occupancy update:
  - +1 on push_in when occupancy < FIFO_SZ.
  - -1 on fifo_pop.
  - Push and pop are mutually exclusive by construction.
- Full push: push_in while occupancy == FIFO_SZ.
  - The FIFO drops its oldest entry. occupancy stays at FIFO_SZ and overflow is set.
  - overflow clears only on reset.
- Cross-check: fifo_full is high only when occupancy == FIFO_SZ.
  - A bench assertion flags any mismatch, except on the cycle after a full push. The FIFO sets fifo_full only on a push at full.
- The reset of this block must be asserted in the same cycles as the mode FIFO's reset.

## Timing
- Reset values:
  - State IDLE.
  - mode_out = 0, mode_valid = 0.
  - occupancy = 0, empty = 1, overflow = 0.
  - fifo_pop = 0.
- Reset takes effect at the next rising edge. It overrides any state, including PRESENT with mode_valid high; an unconsumed code is discarded.
- Latency, push to valid:
  - Push at cycle t gives occupancy = 1 at t+1.
  - fifo_pop is high at t+1 if push_in is low at t+1.
  - CAPT at t+2; mode_valid at t+3.
- Throughput: at most one mode per 3 cycles. Each cycle with push_in high while in IDLE adds one cycle of delay.
- Handshake:
  - mode_out must not change while mode_valid && !mode_ready.
  - mode_valid drops the cycle after acceptance.
- Empty: no pop is issued while occupancy == 0.
- Wrap: occupancy never exceeds FIFO_SZ and never goes below 0.

## Test plan
- Reset: hold reset for 2 cycles -> mode_valid=0, mode_out=0, occupancy=0, empty=1, overflow=0, fifo_pop=0.
- Single mode, mode_ready=1:
  - Push 2'b10 at cycle t -> fifo_pop=1 at t+1, mode_valid=1 with mode_out=2'b10 at t+3.
  - mode_valid=0 at t+4; empty=1 from t+2.
- Ordered burst, mode_ready=1:
  - Push 1, 2, 3 on consecutive cycles -> no fifo_pop during the push cycles.
  - Modes are emitted in order 1, 2, 3, each 3 cycles apart; occupancy ends at 0.
- Overflow, mode_ready=0:
  - Push 6 codes 0, 1, 2, 3, 0, 1 back-to-back -> occupancy saturates at 5 and overflow=1.
  - After release, the outputs are 1, 2, 3, 0, 1.
  - overflow stays 1 until reset.
- Back-pressure: hold mode_ready=0 for 10 cycles in PRESENT -> mode_out is stable, no fifo_pop, occupancy unchanged. Raise mode_ready -> accepted in one cycle.
- Reset mid-operation: assert reset while mode_valid=1 and occupancy=2 -> next cycle mode_valid=0, occupancy=0, state IDLE, and no pop is issued.
